vga_timing_gen: RTL

- Generates 640x480 VGA raster timing from the 25 MHz pixel clock.
- Drives hsync/vsync to the connector.
- Supplies hc, vc and vidon to the pixel/picture generator, which consumes these counters to select colours.
- Also emits per-line and per-frame strobes, used to step animation such as the falling bars.

---
 rtl/vga_timing_gen.sv | 115 +++++++++++
 1 files changed

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: 640x480 VGA raster timing from the 25 MHz pixel clock.
// Optional build macro VGA_FRAME_CNT_EN adds an 8-bit frame counter on
// frame_cnt_o; without it the port is tied to zero.
module vga_timing_gen #(
    parameter int unsigned HPIXELS = 800,
    parameter int unsigned VLINES  = 521,
    parameter int unsigned HSW     = 128,
    parameter int unsigned VSW     = 2,
    parameter int unsigned HBP     = 144,
    parameter int unsigned HFP     = 784,
    parameter int unsigned VBP     = 31,
    parameter int unsigned VFP     = 511
) (
    input  logic       CP_25MHz_i,
    input  logic       clr_i,
    input  logic       ce_i,
    output logic [9:0] hc_o,
    output logic [9:0] vc_o,
    output logic       hsync_o,
    output logic       vsync_o,
    output logic       vidon_o,
    output logic       line_end_o,
    output logic       frame_start_o,
    output logic [7:0] frame_cnt_o
);

    // Last counter values, and window bounds widened to 11 bits so that a
    // bound equal to 1024 still compares correctly against a 10-bit counter.
    localparam logic [9:0]  HMAX  = 10'(HPIXELS - 1);
    localparam logic [9:0]  VMAX  = 10'(VLINES - 1);
    localparam logic [10:0] HSW_W = 11'(HSW);
    localparam logic [10:0] VSW_W = 11'(VSW);
    localparam logic [10:0] HBP_W = 11'(HBP);
    localparam logic [10:0] HFP_W = 11'(HFP);
    localparam logic [10:0] VBP_W = 11'(VBP);
    localparam logic [10:0] VFP_W = 11'(VFP);

    logic [9:0] hc_q, hc_d;
    logic [9:0] vc_q, vc_d;
    logic       fs_q, fs_d;
    logic       h_last, v_last, wrap;

    assign h_last = (hc_q == HMAX);
    assign v_last = (vc_q == VMAX);
    assign wrap   = ce_i && h_last && v_last;

    // Next-state for the raster counters; ce low freezes the position.
    always_comb begin
        hc_d = hc_q;
        vc_d = vc_q;
        if (ce_i) begin
            if (h_last) begin
                hc_d = '0;
                vc_d = v_last ? '0 : vc_q + 10'd1;
            end else begin
                hc_d = hc_q + 10'd1;
            end
        end
    end

    // The frame-start flag is set by the wrap edge and held across ce=0 so the
    // pulse lands on the first enabled cycle at (0,0), never on a stalled one.
    always_comb begin
        fs_d = fs_q;
        if (ce_i) fs_d = wrap;
    end

    // Counter and frame-start registers with synchronous clear.
    always_ff @(posedge CP_25MHz_i) begin
        if (clr_i) begin
            hc_q <= '0;
            vc_q <= '0;
            fs_q <= 1'b0;
        end else begin
            hc_q <= hc_d;
            vc_q <= vc_d;
            fs_q <= fs_d;
        end
    end

`ifdef VGA_FRAME_CNT_EN
    logic [7:0] fc_q, fc_d;

    // Frame count steps on the wrap edge, so it reads the new value together
    // with the frame_start pulse; wraps naturally at 8 bits.
    always_comb begin
        fc_d = fc_q;
        if (wrap) fc_d = fc_q + 8'd1;
    end

    // Frame counter register with synchronous clear.
    always_ff @(posedge CP_25MHz_i) begin
        if (clr_i) fc_q <= '0;
        else       fc_q <= fc_d;
    end

    assign frame_cnt_o = fc_q;
`else
    assign frame_cnt_o = 8'd0;
`endif

    // Zero-latency decodes of the registered position.
    always_comb begin
        hsync_o       = ({1'b0, hc_q} >= HSW_W);
        vsync_o       = ({1'b0, vc_q} >= VSW_W);
        vidon_o       = ({1'b0, hc_q} >= HBP_W) && ({1'b0, hc_q} < HFP_W) &&
                        ({1'b0, vc_q} >= VBP_W) && ({1'b0, vc_q} < VFP_W);
        line_end_o    = ce_i && h_last;
        frame_start_o = ce_i && fs_q;
    end

    assign hc_o = hc_q;
    assign vc_o = vc_q;

endmodule
